// File: rtl/vga_window_scanout.sv
// VGA timing generator with a scaled framebuffer window and read-latency-matched scan-out.
// The CPU side gets a one-cycle vblank pulse and an 8-bit frame counter.
module vga_window_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int FB_W     = 32,
    parameter int FB_H     = 32,
    parameter int SCALE    = 15,
    parameter int WIN_X0   = 80,
    parameter int WIN_Y0   = 0,
    parameter int DATA_W   = 4,
    parameter int RD_LAT   = 1,
    localparam int ADDR_W  = $clog2(FB_W * FB_H)
) (
    input  logic              CLK_25M,
    input  logic              RST,
    input  logic [DATA_W-1:0] border,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd_en,
    input  logic [DATA_W-1:0] fb_data,
    output logic [DATA_W-1:0] pix,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              vblank,
    output logic [7:0]        frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL + 1);
    localparam int V_W     = $clog2(V_TOTAL + 1);
    localparam int SX_W    = $clog2(SCALE + 1);
    localparam int COL_W   = $clog2(FB_W);
    localparam int ROW_W   = ADDR_W - COL_W;
    localparam int DEPTH   = RD_LAT + 1;

    localparam logic [H_W-1:0]  H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]  H_ACT_C  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]  HS_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]  HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_W-1:0]  WX_START = H_W'(WIN_X0);
    localparam logic [H_W-1:0]  WX_END   = H_W'(WIN_X0 + FB_W * SCALE);
    localparam logic [V_W-1:0]  V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]  V_ACT_C  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]  VS_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]  VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0]  WY_START = V_W'(WIN_Y0);
    localparam logic [V_W-1:0]  WY_END   = V_W'(WIN_Y0 + FB_H * SCALE);
    localparam logic [SX_W-1:0] SX_MAX   = SX_W'(SCALE - 1);

    if (WIN_X0 + FB_W * SCALE > H_ACTIVE) begin : g_chk_x
        $error("vga_window_scanout: window exceeds H_ACTIVE");
    end
    if (WIN_Y0 + FB_H * SCALE > V_ACTIVE) begin : g_chk_y
        $error("vga_window_scanout: window exceeds V_ACTIVE");
    end
    if (FB_W < 1 || (FB_W & (FB_W - 1)) != 0) begin : g_chk_fbw
        $error("vga_window_scanout: FB_W must be a power of two");
    end
    if (SCALE < 1) begin : g_chk_scale
        $error("vga_window_scanout: SCALE must be at least 1");
    end

    typedef struct packed {
        logic act;
        logic win;
        logic hs;
        logic vs;
        logic vb;
    } flags_t;

    logic [H_W-1:0]   h, h_nxt;
    logic [V_W-1:0]   v, v_nxt;
    logic [SX_W-1:0]  sx, sy;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             line_end, win_x, win_y;
    flags_t           flags0;
    flags_t           flag_pipe [DEPTH];
    flags_t           flags_out;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        line_end = (h == H_LAST);
        h_nxt    = line_end ? '0 : h + 1'b1;
        v_nxt    = v;
        if (line_end) begin
            v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
        end
    end

    assign win_x      = (h >= WX_START) && (h < WX_END);
    assign win_y      = (v >= WY_START) && (v < WY_END);
    assign flags0.act = (h < H_ACT_C) && (v < V_ACT_C);
    assign flags0.win = win_x && win_y;
    assign flags0.hs  = (h >= HS_START) && (h < HS_END);
    assign flags0.vs  = (v >= VS_START) && (v < VS_END);
    assign flags0.vb  = (h == '0) && (v == V_ACT_C);

    // sx/col and sy/row are steered by the next position so they already match h/v.
    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge CLK_25M or posedge RST) begin
        if (RST) begin
            h   <= '0;
            v   <= '0;
            sx  <= '0;
            col <= '0;
            sy  <= '0;
            row <= '0;
        end else begin
            h <= h_nxt;
            v <= v_nxt;
            if (h_nxt == WX_START) begin
                sx  <= '0;
                col <= '0;
            end else if (sx == SX_MAX) begin
                sx  <= '0;
                col <= col + 1'b1;
            end else begin
                sx <= sx + 1'b1;
            end
            if (line_end) begin
                if (v_nxt == WY_START) begin
                    sy  <= '0;
                    row <= '0;
                end else if (win_y) begin
                    if (sy == SX_MAX) begin
                        sy  <= '0;
                        row <= row + 1'b1;
                    end else begin
                        sy <= sy + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK_25M or posedge RST) begin
        if (RST) begin
            fb_addr  <= '0;
            fb_rd_en <= 1'b0;
        end else begin
            fb_rd_en <= flags0.win;
            if (flags0.win) begin
                fb_addr <= {row, col};
            end
        end
    end

    // NOTE: the flag delay line is a few flops, not a RAM, so it is reset; this is what
    // makes the first LAT cycles after reset emit inactive sync and de=0.
    always_ff @(posedge CLK_25M or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                flag_pipe[i] <= '0;
            end
        end else begin
            flag_pipe[0] <= flags0;
            for (int i = 1; i < DEPTH; i++) begin
                flag_pipe[i] <= flag_pipe[i-1];
            end
        end
    end

    assign flags_out = flag_pipe[DEPTH-1];

    always_ff @(posedge CLK_25M or posedge RST) begin
        if (RST) begin
            pix       <= '0;
            de        <= 1'b0;
            hsync     <= ~HS_POL;
            vsync     <= ~VS_POL;
            vblank    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            de        <= flags_out.act;
            pix       <= flags_out.win ? fb_data : (flags_out.act ? border : '0);
            hsync     <= flags_out.hs ? HS_POL : ~HS_POL;
            vsync     <= flags_out.vs ? VS_POL : ~VS_POL;
            vblank    <= flags_out.vb;
            frame_cnt <= frame_cnt + {7'd0, flags_out.vb};
        end
    end

endmodule
